// File: rtl/fetch_sequencer.sv
// Fetch-control FSM driving the PC datapath (Start/Halt/Branch/Offset) and reporting run status.
// Optional RUN-cycle counter output Cycle_Count is enabled by defining FETCH_SEQ_CYCLE_CNT_EN.
module fetch_sequencer #(
  parameter int PC_W      = 16,
  parameter int OFF_W     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 255
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Go,
  input  logic [PC_W-1:0]  Go_Address,
  input  logic             Mem_Ready,
  input  logic             Halt_Req,
  input  logic             Branch_Taken,
  input  logic [OFF_W-1:0] Branch_Offset,
  output logic             Start,
  output logic [PC_W-1:0]  Start_Address,
  output logic             Halt,
  output logic             Branch,
  output logic [OFF_W-1:0] Offset,
  output logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
`ifdef FETCH_SEQ_CYCLE_CNT_EN
  output logic [31:0]      Cycle_Count,
`endif
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PC_W-1:0]    start_addr_r;
  logic [CNT_W-1:0]   instr_cnt_r;
  logic [STALL_W-1:0] stall_cnt_r;
  logic               flush_r;
  logic               done_r;
  logic               fault_r;
  logic               start_s;
  logic               halt_s;
  logic               branch_s;
  logic [OFF_W-1:0]   offset_s;
  logic               advance_s;
  logic               stall_hit_s;
  logic               launch_s;
`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [31:0]        cycle_cnt_r;
`endif

  // Next-state and combinational datapath controls
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    halt_s      = 1'b1;
    branch_s    = 1'b0;
    offset_s    = '0;
    advance_s   = 1'b0;
    stall_hit_s = 1'b0;
    launch_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (Go) begin
          launch_s    = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        start_s     = 1'b1;
        halt_s      = 1'b0;
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        // Halt_Req outranks Branch_Taken because advance already excludes it
        advance_s   = Mem_Ready && !Halt_Req;
        halt_s      = !advance_s;
        branch_s    = advance_s && Branch_Taken;
        stall_hit_s = !Mem_Ready && (stall_cnt_r == STALL_LAST);
        if (branch_s) begin
          offset_s = Branch_Offset;
        end else begin
          offset_s = '0;
        end
        if (Mem_Ready && Halt_Req) begin
          state_nxt_s = ST_HALTED;
        end else if (stall_hit_s) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run bookkeeping; per-run state is cleared on the launch edge so LOAD already shows it clean
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      start_addr_r <= '0;
      instr_cnt_r  <= '0;
      stall_cnt_r  <= '0;
      flush_r      <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      flush_r <= branch_s;
      if (launch_s) begin
        start_addr_r <= Go_Address;
        instr_cnt_r  <= '0;
        stall_cnt_r  <= '0;
        done_r       <= 1'b0;
        fault_r      <= 1'b0;
      end
      if (state_r == ST_RUN) begin
        if (advance_s && (instr_cnt_r != {CNT_W{1'b1}})) begin
          instr_cnt_r <= instr_cnt_r + CNT_W'(1);
        end
        if (Mem_Ready) begin
          stall_cnt_r <= '0;
        end else if (!stall_hit_s) begin
          stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end
        if (Mem_Ready && Halt_Req) begin
          done_r <= 1'b1;
        end
        if (stall_hit_s) begin
          fault_r <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  // Saturating count of RUN cycles, stalls included
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cycle_cnt_r <= 32'd0;
    end else if (launch_s) begin
      cycle_cnt_r <= 32'd0;
    end else if ((state_r == ST_RUN) && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end
  end

  assign Cycle_Count = cycle_cnt_r;
`endif

  assign Start         = start_s;
  assign Start_Address = start_addr_r;
  assign Halt          = halt_s;
  assign Branch        = branch_s;
  assign Offset        = offset_s;
  assign Flush         = flush_r;
  assign Busy          = (state_r == ST_LOAD) || (state_r == ST_RUN);
  assign Done          = done_r;
  assign Fault         = fault_r;
  assign Instr_Count   = instr_cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each cycle pushes an expected output snapshot, compared after the scenario.
module tb_fetch_sequencer;

  logic        CLK;
  logic        RST_n;
  logic        Go;
  logic [15:0] Go_Address;
  logic        Mem_Ready;
  logic        Halt_Req;
  logic        Branch_Taken;
  logic [7:0]  Branch_Offset;
  logic        Start;
  logic [15:0] Start_Address;
  logic        Halt;
  logic        Branch;
  logic [7:0]  Offset;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [3:0]  Instr_Count;
`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [31:0] Cycle_Count;
`endif

  typedef struct packed {
    logic        start;
    logic        halt;
    logic        branch;
    logic        flush;
    logic        busy;
    logic        done;
    logic        fault;
    logic [7:0]  offset;
    logic [15:0] icnt;
    logic [15:0] saddr;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  string tag_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  fetch_sequencer #(
    .PC_W(16), .OFF_W(8), .CNT_W(4), .MAX_STALL(4)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .Go(Go), .Go_Address(Go_Address),
    .Mem_Ready(Mem_Ready), .Halt_Req(Halt_Req), .Branch_Taken(Branch_Taken),
    .Branch_Offset(Branch_Offset), .Start(Start), .Start_Address(Start_Address),
    .Halt(Halt), .Branch(Branch), .Offset(Offset), .Flush(Flush), .Busy(Busy),
    .Done(Done), .Fault(Fault),
`ifdef FETCH_SEQ_CYCLE_CNT_EN
    .Cycle_Count(Cycle_Count),
`endif
    .Instr_Count(Instr_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic snap_t ex(input logic st, input logic ha, input logic br, input logic fl,
                               input logic bu, input logic dn, input logic ft,
                               input logic [7:0] off, input int ic, input logic [15:0] sa);
    snap_t s;
    s.start = st; s.halt = ha; s.branch = br; s.flush = fl; s.busy = bu;
    s.done = dn; s.fault = ft; s.offset = off; s.icnt = 16'(ic); s.saddr = sa;
    return s;
  endfunction

  function automatic snap_t cap();
    snap_t s;
    s.start = Start; s.halt = Halt; s.branch = Branch; s.flush = Flush; s.busy = Busy;
    s.done = Done; s.fault = Fault; s.offset = Offset; s.icnt = 16'(Instr_Count);
    s.saddr = Start_Address;
    return s;
  endfunction

  // One clock cycle: drive at the falling edge, sample mid low phase, queue the expectation
  task automatic cyc(input logic go, input logic [15:0] ga, input logic mr, input logic hr,
                     input logic bt, input logic [7:0] bo, input string tag, input snap_t e);
    Go = go; Go_Address = ga; Mem_Ready = mr; Halt_Req = hr;
    Branch_Taken = bt; Branch_Offset = bo;
    #1;
    obs_q.push_back(cap());
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    snap_t e, o; string t;
    RST_n = 1'b0;
    @(negedge CLK);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, "rst_hold", ex(0,1,0,0,0,0,0,8'h00,0,16'h0000));
    RST_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "rst_idle", ex(0,1,0,0,0,0,0,8'h00,0,16'h0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_launch();
    snap_t e, o; string t;
    cyc(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 8'h00, "launch_idle", ex(0,1,0,0,0,0,0,8'h00,0,16'h0000));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "launch_load", ex(1,0,0,0,1,0,0,8'h00,0,16'h0040));
    for (int i = 0; i < 4; i++)
      cyc(i >= 2, 16'h1234, 1'b1, 1'b0, 1'b0, 8'h00, "launch_run", ex(0,0,0,0,1,0,0,8'h00,i,16'h0040));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_branch();
    snap_t e, o; string t;
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 8'hFC, "br_take",  ex(0,0,1,0,1,0,0,8'hFC,4,16'h0040));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'hFC, "br_flush", ex(0,0,0,1,1,0,0,8'h00,5,16'h0040));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 8'h10, "br_b2b_a", ex(0,0,1,0,1,0,0,8'h10,6,16'h0040));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 8'h7F, "br_b2b_b", ex(0,0,1,1,1,0,0,8'h7F,7,16'h0040));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h00, "br_b2b_fl", ex(0,0,0,1,1,0,0,8'h00,8,16'h0040));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h00, "br_quiet", ex(0,0,0,0,1,0,0,8'h00,9,16'h0040));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_stall();
    snap_t e, o; string t;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, "stall_1",  ex(0,1,0,0,1,0,0,8'h00,10,16'h0040));
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h20, "stall_br", ex(0,1,0,0,1,0,0,8'h00,10,16'h0040));
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, "stall_hr", ex(0,1,0,0,1,0,0,8'h00,10,16'h0040));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h00, "stall_resume", ex(0,0,0,0,1,0,0,8'h00,10,16'h0040));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_halt_priority();
    snap_t e, o; string t;
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h08, "hp_req",    ex(0,1,0,0,1,0,0,8'h00,11,16'h0040));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "hp_halted", ex(0,1,0,0,0,1,0,8'h00,11,16'h0040));
    cyc(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 8'h00, "hp_go",     ex(0,1,0,0,0,1,0,8'h00,11,16'h0040));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "hp_load",   ex(1,0,0,0,1,0,0,8'h00,0,16'h0100));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "hp_run",    ex(0,0,0,0,1,0,0,8'h00,0,16'h0100));
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, "hp_req2",   ex(0,1,0,0,1,0,0,8'h00,1,16'h0100));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_timeout();
    snap_t e, o; string t;
    cyc(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 8'h00, "to_go",   ex(0,1,0,0,0,1,0,8'h00,1,16'h0100));
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, "to_load", ex(1,0,0,0,1,0,0,8'h00,0,16'h0200));
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, "to_stall", ex(0,1,0,0,1,0,0,8'h00,0,16'h0200));
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, "to_fault", ex(0,1,0,0,0,0,1,8'h00,0,16'h0200));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "to_hold",  ex(0,1,0,0,0,0,1,8'h00,0,16'h0200));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o; string t;
    cyc(1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 8'h00, "ar_go",     ex(0,1,0,0,0,0,1,8'h00,0,16'h0200));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "ar_load",   ex(1,0,0,0,1,0,0,8'h00,0,16'h0300));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h04, "ar_branch", ex(0,0,1,0,1,0,0,8'h04,0,16'h0300));
    RST_n = 1'b0;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h04, "ar_reset",  ex(0,1,0,0,0,0,0,8'h00,0,16'h0000));
    RST_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "ar_idle",   ex(0,1,0,0,0,0,0,8'h00,0,16'h0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_saturate();
    snap_t e, o; string t;
    cyc(1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 8'h00, "sat_go",   ex(0,1,0,0,0,0,0,8'h00,0,16'h0000));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "sat_load", ex(1,0,0,0,1,0,0,8'h00,0,16'h0500));
    for (int i = 0; i < 18; i++)
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "sat_run",
          ex(0,0,0,0,1,0,0,8'h00,(i > 15) ? 15 : i,16'h0500));
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, "sat_halt", ex(0,1,0,0,1,0,0,8'h00,15,16'h0500));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "sat_done", ex(0,1,0,0,0,1,0,8'h00,15,16'h0500));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  task automatic test_cycle_count();
    snap_t e, o; string t;
    cyc(1'b1, 16'h0600, 1'b1, 1'b0, 1'b0, 8'h00, "cc_go",   ex(0,1,0,0,0,1,0,8'h00,15,16'h0500));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "cc_load", ex(1,0,0,0,1,0,0,8'h00,0,16'h0600));
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, "cc_adv", ex(0,0,0,0,1,0,0,8'h00,i,16'h0600));
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, "cc_stall", ex(0,1,0,0,1,0,0,8'h00,5,16'h0600));
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, "cc_halt", ex(0,1,0,0,1,0,0,8'h00,5,16'h0600));
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (Cycle_Count !== 32'd8) begin
        tests_failed++;
        $display("FAIL cc_value: got %0d expected 8", Cycle_Count);
      end
      @(negedge CLK);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask
`endif

  initial begin
    RST_n = 1'b0; Go = 1'b0; Go_Address = 16'h0000; Mem_Ready = 1'b0;
    Halt_Req = 1'b0; Branch_Taken = 1'b0; Branch_Offset = 8'h00;
    test_reset();
    test_launch();
    test_branch();
    test_stall();
    test_halt_priority();
    test_timeout();
    test_async_reset();
    test_saturate();
`ifdef FETCH_SEQ_CYCLE_CNT_EN
    test_cycle_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
